// File: rtl/mdu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl_if
//  Description : Request/response bundle between the E stage and mdu_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_ctrl_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HIWrite;
    logic        LOWrite;
    logic        HIRead;
    logic        LORead;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDRD;

    modport master (
        output Start, MDOp, A, B, HIWrite, LOWrite, HIRead, LORead,
        input  Busy, HI, LO, MDRD
    );

    modport slave (
        input  Start, MDOp, A, B, HIWrite, LOWrite, HIRead, LORead,
        output Busy, HI, LO, MDRD
    );
endinterface
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl
//  Description : Multi-cycle multiply/divide sequencer owning the HI/LO pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mdu_ctrl_if.slave  md
);

    localparam int unsigned c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned c_CNT_W   = $clog2(c_MAX_LAT + 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [1:0]         r_op;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               w_launch;
    logic               w_commit;
    logic               w_valid_op;

    assign w_valid_op = (md.MDOp[2] == 1'b0);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (md.Start && w_valid_op) begin
                    w_launch = 1'b1;
                    w_next   = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_commit = 1'b1;
                    w_next   = c_ST_IDLE;
                end
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    // Even opcodes are signed; one multiplier and one magnitude divider
    // serve both flavours.
    logic        w_sgn;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_div_zero;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_sgn      = ~r_op[0];
    assign w_a_neg    = w_sgn & r_a[31];
    assign w_b_neg    = w_sgn & r_b[31];
    assign w_ext_a    = {{32{w_a_neg}}, r_a};
    assign w_ext_b    = {{32{w_b_neg}}, r_b};
    assign w_prod     = w_ext_a * w_ext_b;
    assign w_mag_a    = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_mag_b    = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_div_zero = (r_b == 32'd0);
    assign w_den      = w_div_zero ? 32'd1 : w_mag_b;
    assign w_q_mag    = w_mag_a / w_den;
    assign w_r_mag    = w_mag_a % w_den;
    assign w_quo      = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
    assign w_res_hi   = r_op[1] ? w_rem : w_prod[63:32];
    assign w_res_lo   = r_op[1] ? w_quo : w_prod[31:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (w_launch) begin
            r_a   <= md.A;
            r_b   <= md.B;
            r_op  <= md.MDOp[1:0];
            r_cnt <= md.MDOp[1] ? c_CNT_W'(DIV_LAT) : c_CNT_W'(MUL_LAT);
        end else if (r_state == c_ST_RUN) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (w_commit && !(r_op[1] && w_div_zero)) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else begin
            if (md.HIWrite) begin
                r_hi <= md.A;
            end
            if (md.LOWrite) begin
                r_lo <= md.A;
            end
        end
    end

    assign md.Busy = (r_state == c_ST_RUN);
    assign md.HI   = r_hi;
    assign md.LO   = r_lo;
    assign md.MDRD = md.HIRead ? r_hi : (md.LORead ? r_lo : 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_ctrl
//  Description : Directed self-checking bench for mdu_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    localparam int c_MUL = 5;
    localparam int c_DIV = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    mdu_ctrl_if md_if ();

    mdu_ctrl #(.MUL_LAT(c_MUL), .DIV_LAT(c_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Launch one op and check Busy is high for exactly lat cycles, low after.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int lat);
        md_if.Start = 1'b1;
        md_if.MDOp  = op;
        md_if.A     = a;
        md_if.B     = b;
        step();
        md_if.Start = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check({tag, "_busy"}, 32'(md_if.Busy), 32'd1);
            step();
        end
        check({tag, "_done"}, 32'(md_if.Busy), 32'd0);
    endtask

    initial begin
        reset          = 1'b0;
        md_if.Start    = 1'b1;
        md_if.MDOp     = 3'b000;
        md_if.A        = 32'd5;
        md_if.B        = 32'd5;
        md_if.HIWrite  = 1'b0;
        md_if.LOWrite  = 1'b0;
        md_if.HIRead   = 1'b1;
        md_if.LORead   = 1'b0;

        // Reset held for two edges with Start asserted
        step();
        step();
        check("rst_busy", 32'(md_if.Busy), 32'd0);
        check("rst_hi",   md_if.HI,   32'd0);
        check("rst_lo",   md_if.LO,   32'd0);
        check("rst_mdrd", md_if.MDRD, 32'd0);
        reset       = 1'b1;
        md_if.Start = 1'b0;
        step();
        check("rel_busy", 32'(md_if.Busy), 32'd0);
        step();
        check("rel_busy2", 32'(md_if.Busy), 32'd0);

        run_op("mult", 3'b000, 32'hFFFF_FFFE, 32'd3, c_MUL);
        check("mult_hi", md_if.HI, 32'hFFFF_FFFF);
        check("mult_lo", md_if.LO, 32'hFFFF_FFFA);

        run_op("multu", 3'b001, 32'hFFFF_FFFE, 32'd3, c_MUL);
        check("multu_hi", md_if.HI, 32'h0000_0002);
        check("multu_lo", md_if.LO, 32'hFFFF_FFFA);

        run_op("div", 3'b010, 32'hFFFF_FFF9, 32'd2, c_DIV);
        check("div_lo", md_if.LO, 32'hFFFF_FFFD);
        check("div_hi", md_if.HI, 32'hFFFF_FFFF);

        run_op("divovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, c_DIV);
        check("divovf_lo", md_if.LO, 32'h8000_0000);
        check("divovf_hi", md_if.HI, 32'h0000_0000);

        run_op("divu", 3'b011, 32'd100, 32'd7, c_DIV);
        check("divu_lo", md_if.LO, 32'd14);
        check("divu_hi", md_if.HI, 32'd2);

        // Invalid opcode is ignored
        md_if.Start = 1'b1;
        md_if.MDOp  = 3'b100;
        step();
        md_if.Start = 1'b0;
        check("inval_busy", 32'(md_if.Busy), 32'd0);
        check("inval_lo",   md_if.LO, 32'd14);

        // mthi / mtlo
        md_if.A       = 32'h11;
        md_if.HIWrite = 1'b1;
        step();
        md_if.HIWrite = 1'b0;
        check("mthi_busy", 32'(md_if.Busy), 32'd0);
        check("mthi_hi",   md_if.HI, 32'h11);
        md_if.A       = 32'h22;
        md_if.LOWrite = 1'b1;
        step();
        md_if.LOWrite = 1'b0;
        check("mtlo_lo", md_if.LO, 32'h22);
        check("mtlo_hi", md_if.HI, 32'h11);

        run_op("divz", 3'b011, 32'd1234, 32'd0, c_DIV);
        check("divz_hi", md_if.HI, 32'h11);
        check("divz_lo", md_if.LO, 32'h22);
        md_if.HIRead = 1'b1;
        md_if.LORead = 1'b1;
        #1;
        check("mdrd_hi", md_if.MDRD, 32'h11);
        md_if.HIRead = 1'b0;
        #1;
        check("mdrd_lo", md_if.MDRD, 32'h22);
        md_if.LORead = 1'b0;
        #1;
        check("mdrd_none", md_if.MDRD, 32'd0);

        // Conflicts: Start+HIWrite in Busy cycle 2, Start on the commit cycle
        md_if.Start = 1'b1;
        md_if.MDOp  = 3'b000;
        md_if.A     = 32'd6;
        md_if.B     = 32'd7;
        step();
        md_if.Start = 1'b0;
        check("cf_busy1", 32'(md_if.Busy), 32'd1);
        step();
        check("cf_busy2", 32'(md_if.Busy), 32'd1);
        md_if.Start   = 1'b1;
        md_if.MDOp    = 3'b010;
        md_if.HIWrite = 1'b1;
        md_if.A       = 32'hDEAD;
        md_if.HIRead  = 1'b1;
        step();
        md_if.Start   = 1'b0;
        md_if.HIWrite = 1'b0;
        check("cf_busy3", 32'(md_if.Busy), 32'd1);
        check("cf_old_hi", md_if.MDRD, 32'h11);
        step();
        step();
        check("cf_busy5", 32'(md_if.Busy), 32'd1);
        md_if.Start = 1'b1;
        md_if.MDOp  = 3'b001;
        md_if.A     = 32'd9;
        md_if.B     = 32'd9;
        step();
        md_if.Start  = 1'b0;
        md_if.HIRead = 1'b0;
        check("cf_done", 32'(md_if.Busy), 32'd0);
        check("cf_hi",   md_if.HI, 32'd0);
        check("cf_lo",   md_if.LO, 32'd42);
        step();
        check("cf_nostart", 32'(md_if.Busy), 32'd0);
        check("cf_lo2",     md_if.LO, 32'd42);

        // Reset in Busy cycle 4 aborts the divide
        md_if.Start = 1'b1;
        md_if.MDOp  = 3'b010;
        md_if.A     = 32'd100;
        md_if.B     = 32'd7;
        step();
        md_if.Start = 1'b0;
        step();
        step();
        step();
        check("ab_busy4", 32'(md_if.Busy), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("ab_busy", 32'(md_if.Busy), 32'd0);
        check("ab_hi",   md_if.HI, 32'd0);
        check("ab_lo",   md_if.LO, 32'd0);
        for (int i = 0; i < c_DIV; i++) begin
            step();
        end
        check("ab_late_busy", 32'(md_if.Busy), 32'd0);
        check("ab_late_hi",   md_if.HI, 32'd0);
        check("ab_late_lo",   md_if.LO, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
